// File: rtl/lfsr_req_arbiter_if.sv
// Request/grant/delivery bundle between lfsr_req_arbiter and its requesters.
// master: requester side; slave: arbiter side.
interface lfsr_req_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rdata;
    logic [IW-1:0]   rid;
    logic            rvalid;

    modport master (output req, input gnt, input rdata, input rid, input rvalid);
    modport slave  (input req, output gnt, output rdata, output rid, output rvalid);
endinterface

// File: rtl/lfsr_req_arbiter.sv
// Round-robin arbiter sharing one lfsr_16 among NREQ requesters; each grant gets STEPS fresh advances.
// Optional zero-word guard with reseed: define LFSR_ARB_ZERO_GUARD_EN.
module lfsr_req_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned STEPS = 16
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_req_arbiter_if.slave  bus,
    output logic               busy,
    output logic               zero_err,
    output logic               lfsr_en,
    output logic               lfsr_rst_n,
    input  logic [15:0]        lfsr_in
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] STEPS_LD = CW'(STEPS);

`ifdef LFSR_ARB_ZERO_GUARD_EN
    typedef enum logic [1:0] {IDLE, STEP, CAPTURE, RESEED} state_t;
`else
    typedef enum logic [1:0] {IDLE, STEP, CAPTURE} state_t;
`endif

    state_t          state;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rdata;
    logic [IW-1:0]   rid;
    logic            rvalid;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;

    // First requester above the last winner, wrapping at NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IW'((32'(ptr) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign lfsr_en = (state == STEP);

`ifdef LFSR_ARB_ZERO_GUARD_EN
    logic zero_err_q;
    assign zero_err = zero_err_q;
`else
    assign zero_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rdata      <= '0;
            rid        <= '0;
            rvalid     <= 1'b0;
            lfsr_rst_n <= 1'b0;
            ptr        <= IW'(NREQ - 1);
            cnt        <= '0;
`ifdef LFSR_ARB_ZERO_GUARD_EN
            zero_err_q <= 1'b0;
`endif
        end else begin
            rvalid     <= 1'b0;
            lfsr_rst_n <= 1'b1;
`ifdef LFSR_ARB_ZERO_GUARD_EN
            zero_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << win;
                        ptr   <= win;
                        cnt   <= STEPS_LD;
                        state <= STEP;
                    end
                end
                STEP: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
`ifdef LFSR_ARB_ZERO_GUARD_EN
                    // Locked-up generator: reseed and rerun the service instead of delivering zero.
                    if (lfsr_in == 16'h0000) begin
                        lfsr_rst_n <= 1'b0;
                        zero_err_q <= 1'b1;
                        state      <= RESEED;
                    end else
`endif
                    begin
                        rdata  <= lfsr_in;
                        rid    <= ptr;
                        rvalid <= 1'b1;
                        gnt    <= '0;
                        state  <= IDLE;
                    end
                end
`ifdef LFSR_ARB_ZERO_GUARD_EN
                RESEED: begin
                    cnt   <= STEPS_LD;
                    state <= STEP;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rdata  = rdata;
    assign bus.rid    = rid;
    assign bus.rvalid = rvalid;
endmodule
